// File: rtl/axi4_mem_slave_id_if.sv
// AXI4 bus bundle for axi4_mem_slave_id: AW/W/B/AR/R channels with master and slave views.
interface axi4_mem_slave_id_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output RREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  RREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi4_mem_slave_id.sv
// AXI4 ID-tagged memory slave: FIXED/INCR/WRAP bursts, SLVERR on illegal or out-of-range beats.
// Burst counters are built only when AXI_MEM_PERF_CNT_EN is defined; otherwise they read 0.
module axi4_mem_slave_id #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 256
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi4_mem_slave_id_if.slave bus,
    output logic [31:0]        wr_burst_cnt,
    output logic [31:0]        rd_burst_cnt
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic burst_ok(input logic [1:0] bt, input logic [2:0] sz, input logic [7:0] ln);
        logic ok;
        ok = (bt != 2'b11) && (int'(sz) <= OFFS);
        if (bt == 2'b10 && !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15))
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_BYTES;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDXW'(a >> OFFS);
    endfunction

    // Wrap bound is re-derived from the current beat: every beat of a wrap stays inside one span window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] sz,
                                                        input logic [1:0] bt,
                                                        input logic [7:0] ln);
        logic [ADDR_WIDTH-1:0] nb, span, lower, nxt;
        nb    = ADDR_WIDTH'(1) << sz;
        nxt   = (a & ~(nb - ADDR_WIDTH'(1))) + nb;
        span  = nb * (ADDR_WIDTH'(ln) + ADDR_WIDTH'(1));
        lower = a & ~(span - ADDR_WIDTH'(1));
        case (bt)
            2'b00:   return a;
            2'b10:   return (nxt == lower + span) ? lower : nxt;
            default: return nxt;
        endcase
    endfunction

    // ---------------- write channel ----------------
    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len, wr_beat;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst;
    logic                  wr_ok, wr_err;
    logic                  w_last_beat, w_beat_bad, w_mem_en;

    assign bus.AWREADY = (w_state == W_IDLE);
    assign bus.WREADY  = (w_state == W_DATA);
    assign w_last_beat = (wr_beat == wr_len);
    assign w_beat_bad  = !wr_ok || !in_range(wr_addr);
    assign w_mem_en    = (w_state == W_DATA) && bus.WVALID && !w_beat_bad;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            wr_addr    <= '0;
            wr_len     <= '0;
            wr_beat    <= '0;
            wr_size    <= '0;
            wr_burst   <= '0;
            wr_ok      <= 1'b0;
            wr_err     <= 1'b0;
            bus.BVALID <= 1'b0;
            bus.BRESP  <= '0;
            bus.BID    <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (bus.AWVALID) begin
                    w_state  <= W_DATA;
                    wr_addr  <= bus.AWADDR;
                    wr_len   <= bus.AWLEN;
                    wr_size  <= bus.AWSIZE;
                    wr_burst <= bus.AWBURST;
                    wr_ok    <= burst_ok(bus.AWBURST, bus.AWSIZE, bus.AWLEN);
                    wr_err   <= 1'b0;
                    wr_beat  <= '0;
                    bus.BID  <= ID_WIDTH'(bus.AWID);
                end
                W_DATA: if (bus.WVALID) begin
                    // Burst ends on WLAST or on beat AWLEN, whichever comes first; a mismatch is an error.
                    if (bus.WLAST || w_last_beat) begin
                        w_state    <= W_RESP;
                        bus.BVALID <= 1'b1;
                        bus.BRESP  <= (wr_err || w_beat_bad || (bus.WLAST != w_last_beat))
                                      ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wr_err  <= wr_err || w_beat_bad;
                        wr_addr <= next_addr(wr_addr, wr_size, wr_burst, wr_len);
                        wr_beat <= wr_beat + 8'd1;
                    end
                end
                W_RESP: if (bus.BREADY) begin
                    w_state    <= W_IDLE;
                    bus.BVALID <= 1'b0;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_mem_en) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (bus.WSTRB[i])
                    mem[word_idx(wr_addr)][8*i +: 8] <= bus.WDATA[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] rd_addr, rd_sel_addr;
    logic [7:0]            rd_len, rd_beat;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst;
    logic                  rd_ok, rd_sel_ok, rd_sel_bad;
    logic [DATA_WIDTH-1:0] rd_sel_data;

    assign bus.ARREADY = (r_state == R_IDLE);

    // Address/data of the beat loaded next: beat 0 on AR accept, otherwise the successor beat.
    always_comb begin
        rd_sel_addr = next_addr(rd_addr, rd_size, rd_burst, rd_len);
        rd_sel_ok   = rd_ok;
        if (r_state == R_IDLE) begin
            rd_sel_addr = bus.ARADDR;
            rd_sel_ok   = burst_ok(bus.ARBURST, bus.ARSIZE, bus.ARLEN);
        end
        rd_sel_bad  = !rd_sel_ok || !in_range(rd_sel_addr);
        rd_sel_data = rd_sel_bad ? '0 : mem[word_idx(rd_sel_addr)];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= R_IDLE;
            rd_addr    <= '0;
            rd_len     <= '0;
            rd_beat    <= '0;
            rd_size    <= '0;
            rd_burst   <= '0;
            rd_ok      <= 1'b0;
            bus.RVALID <= 1'b0;
            bus.RLAST  <= 1'b0;
            bus.RRESP  <= '0;
            bus.RDATA  <= '0;
            bus.RID    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (bus.ARVALID) begin
                    r_state    <= R_DATA;
                    rd_addr    <= bus.ARADDR;
                    rd_len     <= bus.ARLEN;
                    rd_size    <= bus.ARSIZE;
                    rd_burst   <= bus.ARBURST;
                    rd_ok      <= rd_sel_ok;
                    rd_beat    <= '0;
                    bus.RID    <= ID_WIDTH'(bus.ARID);
                    bus.RVALID <= 1'b1;
                    bus.RLAST  <= (bus.ARLEN == 8'd0);
                    bus.RDATA  <= rd_sel_data;
                    bus.RRESP  <= rd_sel_bad ? RESP_SLVERR : RESP_OKAY;
                end
                R_DATA: if (bus.RREADY) begin
                    if (bus.RLAST) begin
                        r_state    <= R_IDLE;
                        bus.RVALID <= 1'b0;
                        bus.RLAST  <= 1'b0;
                    end else begin
                        rd_addr   <= rd_sel_addr;
                        rd_beat   <= rd_beat + 8'd1;
                        bus.RLAST <= (rd_beat + 8'd1 == rd_len);
                        bus.RDATA <= rd_sel_data;
                        bus.RRESP <= rd_sel_bad ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef AXI_MEM_PERF_CNT_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
        end else begin
            if (bus.BVALID && bus.BREADY)
                wr_burst_cnt <= wr_burst_cnt + 32'd1;
            if (bus.RVALID && bus.RREADY && bus.RLAST)
                rd_burst_cnt <= rd_burst_cnt + 32'd1;
        end
    end
`else
    assign wr_burst_cnt = '0;
    assign rd_burst_cnt = '0;
`endif
endmodule
